// File: rtl/cg_pkg.sv
// Shared encodings for the clock-gating control slice.
// State values are fixed because software reads them through o_state.
package cg_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_OFF  = 2'd0;
    localparam logic [ST_W-1:0] ST_WAKE = 2'd1;
    localparam logic [ST_W-1:0] ST_ON   = 2'd2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd3;

endpackage

// File: rtl/clock_enable_controller.sv
// Always-on controller that drives the gated-clock enable: wakes on
// request, stays on while busy, and turns off after an idle timeout.
module clock_enable_controller
    import cg_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 16,
    parameter int WAKE_CYCLES  = 2,
    parameter int CNT_W        = 8
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_wake_req,
    input  logic            i_busy,
    input  logic            i_force_on,
    output logic            o_clock_en,
    output logic            o_wake_ack,
    output logic [ST_W-1:0] o_state
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             req_q;
    logic             pend_q;
    logic             pend_d;
    logic             arm_q;
    logic             arm_d;
    logic             ack_d;
    logic             en_q;
    logic             active;
    logic             rise;

    assign active  = i_wake_req | i_busy | i_force_on;
    assign rise    = i_wake_req & ~req_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // A request seen during wake-up is held in pend and acked one
    // cycle after entering ON, once the gated clock has settled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        arm_d   = 1'b0;
        ack_d   = arm_q;
        unique case (1'b1)
            (state_q == ST_OFF): begin
                pend_d = 1'b0;
                if (active) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                    pend_d  = rise;
                end
            end
            (state_q == ST_WAKE): begin
                pend_d = pend_q | rise;
                if (cnt_q >= WAKE_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    arm_d   = pend_q | rise;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            (state_q == ST_ON): begin
                ack_d = arm_q | rise;
                if (active) begin
                    cnt_d = '0;
                end else if (IDLE_TIMEOUT <= 1) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ONE;
                end
            end
            (state_q == ST_IDLE): begin
                ack_d = arm_q | rise;
                if (active) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (cnt_q >= IDLE_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
                pend_d  = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            arm_q      <= 1'b0;
            en_q       <= 1'b0;
            o_wake_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= i_wake_req;
            pend_q     <= pend_d;
            arm_q      <= arm_d;
            en_q       <= (state_d != ST_OFF);
            o_wake_ack <= ack_d;
        end
    end

    assign o_clock_en = en_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_clock_enable_controller.sv
// Directed bench for clock_enable_controller (defaults: timeout 16, wake 2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_enable_controller;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req;
    logic       busy;
    logic       force_on;
    logic       en;
    logic       ack;
    logic [1:0] st;

    int checks   = 0;
    int failures = 0;

    clock_enable_controller dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_wake_req (req),
        .i_busy     (busy),
        .i_force_on (force_on),
        .o_clock_en (en),
        .o_wake_ack (ack),
        .o_state    (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic en_e,
                        input logic [1:0] st_e, input logic ack_e);
        chk({tag, "_en"}, 32'(en), 32'(en_e));
        chk({tag, "_st"}, 32'(st), 32'(st_e));
        chk({tag, "_ack"}, 32'(ack), 32'(ack_e));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request at edge N: enable after N, ON after N+2, ack after N+3.
    task automatic wake(input string tag);
        req = 1'b1;
        step();
        chk3({tag, "_n0"}, 1'b1, 2'd1, 1'b0);
        step();
        chk3({tag, "_n1"}, 1'b1, 2'd1, 1'b0);
        step();
        chk3({tag, "_n2"}, 1'b1, 2'd2, 1'b0);
        step();
        chk3({tag, "_n3"}, 1'b1, 2'd2, 1'b1);
        req = 1'b0;
    endtask

    task automatic idle_steps(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (en !== 1'b1 || st !== 2'd3 || ack !== 1'b0) bad++;
        end
        chk({tag, "_idle_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        int acks;
        rstn     = 1'b0;
        req      = 1'b0;
        busy     = 1'b0;
        force_on = 1'b0;

        // T1: reset values, release at 20ns
        @(negedge clk);
        chk3("t1_rst", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk3("t1_post", 1'b0, 2'd0, 1'b0);

        // T2: wake latency and state sequence
        wake("t2");
        step();
        chk3("t2_ackdrop", 1'b1, 2'd3, 1'b0);

        // T3: 16 idle cycles then OFF (first idle cycle already taken)
        idle_steps("t3", 14);
        step();
        chk3("t3_off", 1'b0, 2'd0, 1'b0);

        // T4: busy pulse at idle count 10 restarts the full timeout
        wake("t4w");
        idle_steps("t4a", 10);
        busy = 1'b1;
        step();
        chk3("t4_busy", 1'b1, 2'd2, 1'b0);
        busy = 1'b0;
        idle_steps("t4b", 15);
        step();
        chk3("t4_off", 1'b0, 2'd0, 1'b0);

        // T5: request on the expiry cycle wins
        wake("t5w");
        idle_steps("t5", 15);
        req = 1'b1;
        step();
        chk3("t5_win", 1'b1, 2'd2, 1'b1);
        step();
        chk3("t5_hold1", 1'b1, 2'd2, 1'b0);
        step();
        chk3("t5_hold2", 1'b1, 2'd2, 1'b0);

        // T1 mid-ON: asynchronous reset drops outputs immediately
        req  = 1'b0;
        rstn = 1'b0;
        #1;
        chk3("t1_mid", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        chk3("t1_mid_hold", 1'b0, 2'd0, 1'b0);
        rstn = 1'b1;
        step();
        chk3("t1_mid_rel", 1'b0, 2'd0, 1'b0);

        // T6: force_on holds the enable, no ack, timeout after release
        force_on = 1'b1;
        step();
        chk3("t6_wake", 1'b1, 2'd1, 1'b0);
        bad  = 0;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (en !== 1'b1) bad++;
            if (ack !== 1'b0) acks++;
        end
        chk("t6_en_drop", 32'(bad), 32'd0);
        chk("t6_state_on", 32'(st), 32'd2);
        force_on = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (en !== 1'b1) bad++;
            if (ack !== 1'b0) acks++;
        end
        chk("t6_release_en", 32'(bad), 32'd0);
        chk("t6_release_st", 32'(st), 32'd3);
        step();
        chk3("t6_off", 1'b0, 2'd0, 1'b0);
        chk("t6_no_ack", 32'(acks), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
